// File: rtl/capture_timer.sv
// capture_timer: input-capture peripheral on the 16-bit I/O bus.
// A free-running tick counter (now) timestamps edges on capture_in; the
// timestamps are queued in a small FIFO that the CPU pops through DATA.
module capture_timer #(
    parameter int CLOCK_FREQUENCY  = 50_000_000,
    parameter int TICKS_PER_SECOND = 1000,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        wr_en,
    input  logic [1:0]  addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    input  logic        capture_in,
    output logic        irq
);

    localparam logic [23:0] PRESCALE = 24'(CLOCK_FREQUENCY / TICKS_PER_SECOND - 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    logic [23:0]   r_presc;
    logic [15:0]   r_now;
    logic          r_enable;
    logic          r_edge_sel;
    logic          r_ovf;
    logic          r_s1, r_s2, r_s3;
    logic          r_edge_q;
    logic [15:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [LW-1:0] r_level;
    logic          r_irq;

    logic          w_rd;
    logic          w_wr;
    logic          w_ctrl_wr;
    logic          w_now_wr;
    logic          w_flush;
    logic          w_ovf_clr;
    logic          w_tick;
    logic          w_edge;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [LW-1:0] w_level_nxt;
    logic          w_ovf_nxt;

    // Bus decode, edge detect and FIFO bookkeeping for the coming edge.
    always_comb begin
        w_rd      = en & ~wr_en;
        w_wr      = en & wr_en;
        w_ctrl_wr = w_wr & (addr == 2'd1);
        w_now_wr  = w_wr & (addr == 2'd2);
        w_flush   = w_ctrl_wr & data_in[12];
        w_ovf_clr = w_ctrl_wr & data_in[13];
        w_tick    = r_enable & (r_presc == PRESCALE);
        w_edge    = r_enable & (r_edge_sel ? (~r_s2 & r_s3) : (r_s2 & ~r_s3));
        w_empty   = (r_level == '0);
        w_full    = (r_level == DEPTH_L);
        w_pop     = w_rd & (addr == 2'd0) & ~w_empty;
        // A pop frees the slot the push needs, so a full FIFO still accepts it.
        w_push    = r_edge_q & ~w_flush & (~w_full | w_pop);
        w_drop    = r_edge_q & ~w_flush & w_full & ~w_pop;

        w_level_nxt = r_level;
        if (w_flush) begin
            w_level_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_level_nxt = r_level + LW'(1);
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - LW'(1);
        end

        // A drop in the same cycle as a clear still leaves overflow set.
        w_ovf_nxt = (r_ovf & ~w_ovf_clr) | w_drop;
    end

    // Read mux; DATA returns 0 when nothing is queued.
    always_comb begin
        data_out = 16'h0000;
        case (addr)
            2'd0:    data_out = w_empty ? 16'h0000 : r_mem[r_rp];
            2'd1:    data_out = {r_enable, r_edge_sel, r_ovf, w_empty, 8'h00, 4'(r_level)};
            2'd2:    data_out = r_now;
            default: data_out = 16'h0000;
        endcase
    end

    // Prescaler and tick counter; a NOW write restarts the current tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_now   <= '0;
        end else if (w_now_wr) begin
            r_presc <= '0;
            r_now   <= data_in;
        end else if (r_enable) begin
            if (w_tick) begin
                r_presc <= '0;
                r_now   <= r_now + 16'd1;
            end else begin
                r_presc <= r_presc + 24'd1;
            end
        end
    end

    // Pin synchronizer, history flop and registered edge pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_s3     <= 1'b0;
            r_edge_q <= 1'b0;
        end else begin
            r_s1     <= capture_in;
            r_s2     <= r_s1;
            r_s3     <= r_s2;
            r_edge_q <= w_edge;
        end
    end

    // Control bits and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_enable   <= 1'b0;
            r_edge_sel <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_enable   <= data_in[15];
                r_edge_sel <= data_in[14];
            end
            r_ovf <= w_ovf_nxt;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            r_level <= w_level_nxt;
            if (w_flush) begin
                r_wp <= '0;
                r_rp <= '0;
            end else begin
                if (w_push) r_wp <= r_wp + PW'(1);
                if (w_pop)  r_rp <= r_rp + PW'(1);
            end
        end
    end

    // FIFO storage; contents are only visible through level, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= r_now;
    end

    // Interrupt reflects the state being loaded at this edge.
    always_ff @(posedge clk) begin
        if (!rst_n) r_irq <= 1'b0;
        else        r_irq <= (w_level_nxt != '0) | w_ovf_nxt;
    end

    assign irq = r_irq;

endmodule

// File: tb/tb_capture_timer.sv
// tb_capture_timer: directed test of capture_timer with PRESCALE=9, FIFO_DEPTH=4.
`timescale 1ns/1ps
module tb_capture_timer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [15:0] data_in = 16'h0000;
    logic [15:0] data_out;
    logic        capture_in = 1'b0;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] v;

    capture_timer #(
        .CLOCK_FREQUENCY (10),
        .TICKS_PER_SECOND(1),
        .FIFO_DEPTH      (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .wr_en     (wr_en),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .capture_in(capture_in),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        en = 1'b1; wr_en = 1'b1; addr = a; data_in = d;
        @(negedge clk);
        en = 1'b0; wr_en = 1'b0; data_in = 16'h0000;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
        @(negedge clk);
        en = 1'b1; wr_en = 1'b0; addr = a;
        #1 d = data_out;
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic wait_now(input logic [15:0] target);
        logic [15:0] cur;
        cur = 16'hDEAD;
        for (int i = 0; i < 100; i++) begin
            bus_read(2'd2, cur);
            if (cur == target) break;
        end
        if (cur != target) chk("wait_now timeout", cur, target);
    endtask

    task automatic pulse();
        @(negedge clk);
        capture_in = 1'b1;
        idle(3);
        capture_in = 1'b0;
        idle(4);
    endtask

    task automatic chk_status(input string tag, input logic [15:0] exp);
        logic [15:0] s;
        bus_read(2'd1, s);
        chk(tag, s, exp);
    endtask

    initial begin
        // Reset state
        idle(3);
        rst_n = 1'b1;
        #1;
        chk("reset irq", {15'd0, irq}, 16'h0000);
        chk_status("reset status", 16'h1000);
        bus_read(2'd2, v); chk("reset now", v, 16'h0000);
        bus_read(2'd0, v); chk("reset data", v, 16'h0000);
        bus_read(2'd3, v); chk("reset addr3", v, 16'h0000);
        idle(20);
        bus_read(2'd2, v); chk("now frozen when disabled", v, 16'h0000);

        // 1: tick rate and wrap
        bus_write(2'd1, 16'h8000);
        idle(35);
        bus_read(2'd2, v); chk("now after 35", v, 16'h0003);
        bus_write(2'd2, 16'hFFFF);
        idle(10);
        bus_read(2'd2, v); chk("now wrap", v, 16'h0000);

        // 2: rising edge capture and pop
        wait_now(16'd5);
        capture_in = 1'b1;
        idle(5);
        chk_status("t2 status", 16'h8001);
        chk("t2 irq set", {15'd0, irq}, 16'h0001);
        bus_read(2'd0, v); chk("t2 data", v, 16'h0005);
        chk("t2 irq clear", {15'd0, irq}, 16'h0000);
        chk_status("t2 empty", 16'h9000);

        // 3: falling-edge select, disabled pulses ignored
        bus_write(2'd1, 16'h4000);
        capture_in = 1'b0;
        idle(5);
        chk_status("t3 disabled fall", 16'h5000);
        bus_write(2'd2, 16'h0000);
        bus_write(2'd1, 16'hC000);
        capture_in = 1'b1;
        idle(6);
        chk_status("t3 rise ignored", 16'hD000);
        wait_now(16'd7);
        capture_in = 1'b0;
        idle(5);
        chk_status("t3 fall pushed", 16'hC001);
        bus_read(2'd0, v); chk("t3 data", v, 16'h0007);
        bus_write(2'd1, 16'h4000);
        pulse();
        pulse();
        chk_status("t3 disabled pulses", 16'h5000);
        chk("t3 irq", {15'd0, irq}, 16'h0000);

        // 4: overflow on the fifth edge
        bus_write(2'd2, 16'h0000);
        bus_write(2'd1, 16'h8000);
        for (int k = 1; k <= 5; k++) begin
            wait_now(16'(k));
            pulse();
        end
        chk_status("t4 full ovf", 16'hA004);
        chk("t4 irq", {15'd0, irq}, 16'h0001);
        for (int k = 1; k <= 4; k++) begin
            bus_read(2'd0, v); chk("t4 data order", v, 16'(k));
        end
        bus_read(2'd0, v); chk("t4 data empty", v, 16'h0000);
        chk_status("t4 empty ovf", 16'hB000);
        chk("t4 irq ovf only", {15'd0, irq}, 16'h0001);
        bus_write(2'd1, 16'hA000);
        chk_status("t4 ovf cleared", 16'h9000);
        chk("t4 irq cleared", {15'd0, irq}, 16'h0000);

        // 5: push and pop together while full, then flush
        repeat (4) pulse();
        chk_status("t5 full", 16'h8004);
        @(negedge clk);
        capture_in = 1'b1;
        idle(2);
        bus_read(2'd0, v);
        chk_status("t5 push+pop full", 16'h8004);
        capture_in = 1'b0;
        idle(5);
        chk_status("t5 falling ignored", 16'h8004);
        bus_write(2'd1, 16'h9000);
        chk_status("t5 flushed", 16'h9000);
        chk("t5 irq", {15'd0, irq}, 16'h0000);

        // 6: reset with level=3 and overflow set
        repeat (5) pulse();
        bus_read(2'd0, v);
        chk_status("t6 before reset", 16'hA003);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t6 irq", {15'd0, irq}, 16'h0000);
        chk_status("t6 status", 16'h1000);
        bus_read(2'd2, v); chk("t6 now", v, 16'h0000);
        bus_read(2'd0, v); chk("t6 data", v, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
